// File: rtl/port_req_gen.sv
// Input-port request generator: buffers flits in a small FIFO, requests the
// output port named by each head flit, and streams the packet once granted.
module port_req_gen #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int NPORT  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_flit,
  output logic              in_ready,
  output logic [NPORT-1:0]  req,
  input  logic [NPORT-1:0]  gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_flit,
  input  logic              out_ready,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // Handshakes: a flit moves on a rising edge where valid && ready are both
  // high; valid never waits on ready, and ready comes from registered state.

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_ONE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, empty, gnt_hit, err_nx, dest_ok;
  logic [NPORT-1:0]  req_nx;
  logic [1:0]        head_type;
  logic [3:0]        head_dest;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid && in_ready;
  assign out_flit  = mem[rd_ptr];
  assign head_type = out_flit[DATA_W-1:DATA_W-2];
  assign head_dest = out_flit[3:0];
  assign dest_ok   = (int'(head_dest) < NPORT);
  // req holds exactly the latched destination bit, so it doubles as the grant mask.
  assign gnt_hit   = |(gnt & req);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      req    <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      req   <= req_nx;
      err   <= err_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_nx  = state;
    req_nx    = req;
    err_nx    = 1'b0;
    pop       = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          case (head_type)
            T_HEAD, T_ONE: begin
              if (dest_ok) begin
                req_nx   = NPORT'(1) << head_dest;
                state_nx = ST_REQ;
              end else begin
                pop      = 1'b1;
                err_nx   = 1'b1;
                state_nx = (head_type == T_ONE) ? ST_IDLE : ST_DROP;
              end
            end
            default: begin
              pop    = 1'b1;
              err_nx = 1'b1;
            end
          endcase
        end
      end
      ST_DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_type == T_TAIL || head_type == T_ONE) state_nx = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (gnt_hit) state_nx = ST_XFER;
      end
      ST_XFER: begin
        out_valid = gnt_hit && !empty;
        pop       = out_valid && out_ready;
        if (pop && head_type[1]) begin
          req_nx   = '0;
          state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait for the arbiter to drop its grant before a new request can form.
        if (gnt == '0) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_port_req_gen.sv
// Bench for port_req_gen: directed packet scenarios plus a randomized packet
// stream scored against a packet-level model of expected output and errors.
module tb_port_req_gen;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int NPORT  = 10;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_ONE  = 2'b11;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RELEASE = 3'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_flit = '0;
  logic              in_ready;
  logic [NPORT-1:0]  req;
  logic [NPORT-1:0]  gnt = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_flit;
  logic              out_ready = 1'b0;
  logic              err;
  logic [2:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  int exp_err  = 0;
  int arb_cnt  = 0;
  int seq      = 0;
  logic acc    = 1'b0;
  logic [NPORT-1:0]  req_seen;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] flit_q[$];
  logic [NPORT-1:0]  got_req_q[$];
  int                exp_dest_q[$];
  logic [DATA_W-1:0] f[5];

  always #5 clk = ~clk;

  port_req_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NPORT(NPORT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .req(req), .gnt(gnt), .out_valid(out_valid),
    .out_flit(out_flit), .out_ready(out_ready), .err(err), .state_dbg(state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_head(input logic [1:0] t, input int dest);
    logic [9:0] s;
    logic [3:0] d;
    seq++;
    s = seq[9:0];
    d = dest[3:0];
    return {t, s, d};
  endfunction

  function automatic logic [DATA_W-1:0] mk_body(input logic [1:0] t);
    logic [13:0] s;
    seq++;
    s = seq[13:0];
    return {t, s};
  endfunction

  // Observe just after inputs settle; a handshake seen here completes at the next posedge.
  task automatic sample();
    #1;
    check("req_onehot0", 32'($onehot0(req)), 1);
    if (out_valid) check("ov_needs_gnt", 32'(|(gnt & req)), 1);
    if (out_valid && out_ready) begin
      got_q.push_back(out_flit);
      got_req_q.push_back(req);
    end
    if (err) err_cnt++;
    req_seen |= req;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cmp_got(input string tag, input int n);
    check(tag, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) check(tag, got_q[i], f[i]);
  endtask

  task automatic reset_dut();
    rst = 1'b0; in_valid = 1'b0; gnt = '0; out_ready = 1'b0;
    @(negedge clk); #1;
    check("rst_req", req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", state_dbg, S_IDLE);
    @(negedge clk);
    rst = 1'b1;
    got_q.delete(); got_req_q.delete();
    err_cnt = 0; req_seen = '0; acc = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_four_no_gnt();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_flit = f[k];
      sample(); step();
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_cycle();
    logic [DATA_W-1:0] fo;
    logic [NPORT-1:0]  ro;
    step();
    if (acc) begin
      void'(flit_q.pop_front());
      in_valid = 1'b0;
    end
    if (!in_valid && flit_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      in_valid = 1'b1;
      in_flit  = flit_q[0];
    end
    if (req == '0) begin
      if (gnt != '0) begin
        if (arb_cnt == 0) gnt = '0; else arb_cnt--;
      end
    end else if (gnt == '0) begin
      if (arb_cnt == 0) begin gnt = req; arb_cnt = $urandom_range(0, 2); end
      else arb_cnt--;
    end else if ($urandom_range(0, 7) == 0) begin
      gnt = '0; arb_cnt = $urandom_range(0, 3);
    end
    out_ready = ($urandom_range(0, 3) != 0);
    sample();
    acc = in_valid && in_ready;
    while (got_q.size() > 0) begin
      fo = got_q.pop_front();
      ro = got_req_q.pop_front();
      if (exp_q.size() == 0) check("rand_extra_flit", fo, 0);
      else begin
        check("rand_flit", fo, exp_q.pop_front());
        check("rand_req", ro, 32'(1) << exp_dest_q.pop_front());
      end
    end
  endtask

  initial begin
    // Head dest 3, body, tail; grant two cycles after req.
    reset_dut();
    f[0] = mk_head(T_HEAD, 3); f[1] = mk_body(T_BODY); f[2] = mk_body(T_TAIL);
    in_valid = 1'b1; in_flit = f[0];
    sample(); check("s1_in_ready", in_ready, 1); step();
    in_flit = f[1]; sample(); step();
    in_flit = f[2]; sample(); check("s1_req", req, 10'h008); step();
    in_valid = 1'b0; gnt = 10'h008; out_ready = 1'b1;
    sample(); check("s1_no_early_out", out_valid, 0); step();
    sample(); check("s1_first_out", out_valid, 1); step();
    sample(); step();
    sample(); step();
    sample();
    check("s1_req_clear", req, 0);
    check("s1_release", state_dbg, S_RELEASE);
    check("s1_ov_release", out_valid, 0);
    gnt = '0; step();
    sample(); check("s1_idle", state_dbg, S_IDLE); step();
    cmp_got("s1_out", 3);

    // Single-flit packet to port 9; RELEASE holds while grant lingers.
    reset_dut();
    f[0] = mk_head(T_ONE, 9);
    in_valid = 1'b1; in_flit = f[0]; sample(); step();
    in_valid = 1'b0; sample(); step();
    sample(); check("s2_req", req, 10'h200);
    gnt = 10'h200; out_ready = 1'b1; step();
    sample(); step();
    for (int i = 0; i < 3; i++) begin
      sample();
      check("s2_hold_release", state_dbg, S_RELEASE);
      check("s2_req_zero", req, 0);
      check("s2_ov_zero", out_valid, 0);
      step();
    end
    gnt = '0; sample(); step();
    sample(); check("s2_idle", state_dbg, S_IDLE); step();
    cmp_got("s2_out", 1);
    check("s2_req_seen", req_seen, 10'h200);

    // Head with dest 12: whole packet discarded, one error pulse.
    reset_dut();
    f[0] = mk_head(T_HEAD, 12); f[1] = mk_body(T_BODY);
    f[2] = mk_body(T_BODY);     f[3] = mk_body(T_TAIL);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_flit = f[k]; gnt = req; sample(); step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin gnt = req; sample(); step(); end
    check("s3_err_pulses", err_cnt, 1);
    check("s3_req_never", req_seen, 0);
    check("s3_no_out", got_q.size(), 0);
    check("s3_idle", state_dbg, S_IDLE);

    // FIFO full: fifth flit refused, four emerge in order.
    reset_dut();
    f[0] = mk_head(T_HEAD, 1); f[1] = mk_body(T_BODY); f[2] = mk_body(T_BODY);
    f[3] = mk_body(T_TAIL);    f[4] = mk_head(T_ONE, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_flit = f[k];
      sample(); check("s4_in_ready", in_ready, (k < 4) ? 1 : 0); step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin gnt = req; sample(); step(); end
    cmp_got("s4_out", 4);
    check("s4_req_end", req, 0);
    check("s4_idle", state_dbg, S_IDLE);
    check("s4_in_ready_end", in_ready, 1);

    // Grant withdrawn for three cycles mid-packet.
    reset_dut();
    f[0] = mk_head(T_HEAD, 5); f[1] = mk_body(T_BODY);
    f[2] = mk_body(T_BODY);    f[3] = mk_body(T_TAIL);
    push_four_no_gnt();
    gnt = 10'h020; out_ready = 1'b1; sample(); step();
    sample(); step();
    for (int i = 0; i < 3; i++) begin
      gnt = '0; sample();
      check("s5_ov_low", out_valid, 0);
      check("s5_req_held", req, 10'h020);
      step();
    end
    for (int i = 0; i < 8; i++) begin gnt = req; sample(); step(); end
    cmp_got("s5_out", 4);

    // Asynchronous reset during XFER with two flits still buffered.
    reset_dut();
    f[0] = mk_head(T_HEAD, 2); f[1] = mk_body(T_BODY);
    f[2] = mk_body(T_BODY);    f[3] = mk_body(T_TAIL);
    push_four_no_gnt();
    gnt = 10'h004; out_ready = 1'b1;
    sample(); step();
    sample(); step();
    sample(); step();
    #2 rst = 1'b0;
    #1;
    check("s6_req", req, 0);
    check("s6_ov", out_valid, 0);
    check("s6_in_ready", in_ready, 1);
    check("s6_state", state_dbg, S_IDLE);
    @(negedge clk);
    rst = 1'b1; gnt = '0; req_seen = '0;
    for (int i = 0; i < 6; i++) begin gnt = req; sample(); step(); end
    check("s6_out_before_rst", got_q.size(), 2);
    check("s6_req_after", req_seen, 0);

    // Randomized packet stream against the packet-level model.
    reset_dut();
    exp_q.delete(); exp_dest_q.delete(); flit_q.delete(); exp_err = 0;
    for (int p = 0; p < 80; p++) begin
      int dest, len;
      logic [DATA_W-1:0] fl;
      if ($urandom_range(0, 9) == 0) begin
        fl = mk_body(($urandom_range(0, 1) == 0) ? T_BODY : T_TAIL);
        flit_q.push_back(fl);
        exp_err++;
      end else begin
        dest = $urandom_range(0, 15);
        len  = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
          if (len == 1)          fl = mk_head(T_ONE, dest);
          else if (i == 0)       fl = mk_head(T_HEAD, dest);
          else if (i == len - 1) fl = mk_body(T_TAIL);
          else                   fl = mk_body(T_BODY);
          flit_q.push_back(fl);
          if (dest < NPORT) begin
            exp_q.push_back(fl);
            exp_dest_q.push_back(dest);
          end
        end
        if (dest >= NPORT) exp_err++;
      end
    end
    begin
      int cyc;
      cyc = 0;
      while ((flit_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
        rand_cycle();
        cyc++;
      end
      check("rand_in_time", (cyc < 20000) ? 1 : 0, 1);
      repeat (20) rand_cycle();
    end
    check("rand_all_out", exp_q.size(), 0);
    check("rand_err_count", err_cnt, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
